// File: rtl/handshake_fifo_source.sv
// Buffered graph input stage: a circular FIFO filled through a write port and
// drained to a downstream operator with the req/ack pulse protocol.
module handshake_fifo_source #(
  parameter int                    data_width    = 32,
  parameter int                    depth_log2    = 4,
  parameter logic [data_width-1:0] initial_value = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level,
  output logic                  overflow,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [31:0]           count
);

  localparam int unsigned             depth      = 2 ** depth_log2;
  localparam logic [depth_log2:0]     level_full = (depth_log2 + 1)'(depth);
  localparam logic [depth_log2:0]     level_one  = (depth_log2 + 1)'(1);
  localparam logic [depth_log2-1:0]   ptr_one    = depth_log2'(1);

  logic [data_width-1:0] mem [depth];
  logic [depth_log2-1:0] rd_ptr;
  logic [depth_log2-1:0] wr_ptr;
  logic                  wr_accept;
  logic                  grant;

  assign full      = (level == level_full);
  assign empty     = (level == '0);
  assign wr_accept = wr_en & ~full;
  assign grant     = req & ~ack & ~empty;

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack      <= 1'b0;
      dout     <= initial_value;
      count    <= '0;
      overflow <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
    end else begin
      ack <= grant;
      if (grant) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ptr_one;
        count  <= count + 32'd1;
      end
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ptr_one;
      end else if (wr_en) begin
        overflow <= 1'b1;
      end
      if (wr_accept && !grant) begin
        level <= level + level_one;
      end else if (grant && !wr_accept) begin
        level <= level - level_one;
      end
    end
  end

endmodule

// File: doc/handshake_fifo_source.md
Name: handshake_fifo_source

Overview:
- Buffered input stage for the dataflow graph. It sits directly upstream of a graph's "in" operator.
- Software/bench logic pushes words through a simple write port into a circular FIFO.
- The block serves those words to the graph's input using the req/ack pulse protocol the operators use.
- It replaces the free-running producer when the input sequence must be arbitrary, and reports delivered count and overflow.

Parameters:
- data_width, 32, width of each data word.
- depth_log2, 4, FIFO depth is 2**depth_log2 entries (default 16).
- initial_value, 0, value driven on dout at reset.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  write strobe; one word per cycle when accepted.
- wr_data  input  data_width  word to enqueue.
- full  output  1  FIFO holds 2**depth_log2 words.
- empty  output  1  FIFO holds 0 words.
- level  output  depth_log2+1  current occupancy.
- overflow  output  1  sticky; set when wr_en is asserted while full.
- req  input  1  level request from the downstream operator's req_l.
- ack  output  1  one-cycle pulse; the word on dout is valid at its rising edge.
- dout  output  data_width  delivered word, registered.
- count  output  32  number of words delivered since reset.

Behaviour:
- Reset (async, rst=1) forces: ack=0, dout=initial_value, count=0, overflow=0, rd_ptr=0, wr_ptr=0, level=0, full=0, empty=1.
  - Takes effect without a clock edge.
  - Memory contents are don't-care.
- Storage: 2**depth_log2 x data_width array.
  - rd_ptr and wr_ptr are depth_log2 bits and wrap modulo depth with no special case at the wrap boundary.
  - level is a separate depth_log2+1-bit counter.
  - full = (level == 2**depth_log2); empty = (level == 0). Both are derived from registered level.
- Write side, evaluated each posedge clk:
  - wr_en & ~full: mem[wr_ptr] <= wr_data; wr_ptr++.
  - wr_en & full: word is dropped, overflow <= 1 (sticky until reset), pointers unchanged.
  - full is evaluated on the pre-edge level. A write in the same cycle as a read while full is still rejected.
- Read side (handshake), evaluated each posedge clk:
  - Default: ack <= 0.
  - If req & ~ack & ~empty: ack <= 1, dout <= mem[rd_ptr], rd_ptr++, count++.
  - dout changes only in the same edge that raises ack, then holds until the next transfer.
  - Maximum rate is one word per 2 cycles, because ack must be low before the next grant.
  - req low, or empty: no ack. The downstream keeps req high, so no word is lost.
  - Latency: a word written at edge N, into an empty FIFO with req high, is acked at edge N+1 at the earliest.
  - A read never observes a write from the same edge.
- level update per edge: +1 on an accepted write only, -1 on a grant only, unchanged on both or neither.
  - Simultaneous accepted write and grant keep level constant and move both pointers.
- count wraps at 2**32 silently.
- Reset mid-transfer: ack drops immediately. The word at rd_ptr is discarded along with all FIFO contents.
- No combinational path from req or wr_en to any output; all outputs are registered or derived from level.

Test Plan:
- Reset then idle: rst pulse with req=1 and no writes -> ack stays 0 for 20 cycles; dout=0, empty=1, level=0, count=0.
- Ordered delivery: write 5,6,7 on consecutive cycles, req held 1 -> three ack pulses spaced 2 cycles apart with dout 5,6,7; first ack 1 cycle after the write of 5; count=3; empty=1 afterwards.
- Full/overflow: depth_log2=2, req=0, write 10..14 -> level=4 and full=1 after the 4th write; 14 is dropped; overflow=1. Then raise req -> delivers 10,11,12,13 only; overflow stays 1.
- Wrap and concurrency: depth_log2=2, 200 random words written while req toggles randomly -> delivered sequence equals written sequence with no drops (writer obeys full); level never exceeds 4; pointers wrap more than 40 times.
- Graph integration: connect to the arf input and feed 0..99 -> out_4 consumer receives 3*x+2 for each x, in order; count=100.
- Async reset mid-transfer: assert rst between clock edges on the cycle ack=1 with level=3 -> ack, level and count read 0 before the next posedge; after release, req=1 produces no ack until a new write.
